// File: rtl/display_pixel_serializer.sv
// Wide framebuffer beat to single-pixel AXI stream serializer with frame-boundary tracking.
// Each beat is buffered whole and emitted one pixel at a time, pixel 0 from the low bits first.
module display_pixel_serializer #(
    parameter int IN_WIDTH     = 64,
    parameter int PIXEL_WIDTH  = 16,
    parameter int FRAME_PIXELS = 153600
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [IN_WIDTH-1:0]    s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                   frame_error
);

    localparam int N     = IN_WIDTH / PIXEL_WIDTH;
    localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
    localparam int CNT_W = (FRAME_PIXELS > 2) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);

    function automatic logic [PIXEL_WIDTH-1:0] pixel_at(
        input logic [IN_WIDTH-1:0] beat,
        input logic [IDX_W-1:0]    sel
    );
        logic [PIXEL_WIDTH-1:0] pix;
        pix = {PIXEL_WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            pix = pix | ({PIXEL_WIDTH{sel == IDX_W'(i)}} & beat[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
        return pix;
    endfunction

    logic [IN_WIDTH-1:0]    beat_r;
    logic                   beat_valid_r;
    logic                   beat_last_r;
    logic [IDX_W-1:0]       idx_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [PIXEL_WIDTH-1:0] tdata_r;
    logic                   tlast_r;
    logic                   frame_error_r;

    logic                   beat_end_s;
    logic                   s_ready_s;
    logic                   xfer_s;
    logic                   accept_s;
    logic [IN_WIDTH-1:0]    beat_nxt_s;
    logic                   beat_valid_nxt_s;
    logic                   beat_last_nxt_s;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   tlast_nxt_s;
    logic                   frame_error_nxt_s;

    // Next-state computation; outputs are registered from the next-state values.
    always_comb begin
        beat_end_s        = (idx_r == IDX_LAST);
        s_ready_s         = !beat_valid_r || (m_axis_tready && beat_end_s);
        xfer_s            = beat_valid_r && m_axis_tready;
        accept_s          = s_axis_tvalid && s_ready_s;
        beat_nxt_s        = beat_r;
        beat_valid_nxt_s  = beat_valid_r;
        beat_last_nxt_s   = beat_last_r;
        idx_nxt_s         = idx_r;
        cnt_nxt_s         = cnt_r;
        frame_error_nxt_s = 1'b0;

        if (xfer_s) begin
            cnt_nxt_s = tlast_r ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
            frame_error_nxt_s = beat_last_r && beat_end_s && (cnt_r != CNT_LAST);
            if (beat_end_s) begin
                idx_nxt_s        = {IDX_W{1'b0}};
                beat_valid_nxt_s = 1'b0;
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // A beat is only accepted with idx already at 0 (empty buffer or final pixel leaving).
        if (accept_s) begin
            beat_nxt_s       = s_axis_tdata;
            beat_last_nxt_s  = s_axis_tlast;
            beat_valid_nxt_s = 1'b1;
        end else begin
            beat_nxt_s = beat_nxt_s;
        end

        tlast_nxt_s = beat_valid_nxt_s &&
                      ((cnt_nxt_s == CNT_LAST) || (beat_last_nxt_s && (idx_nxt_s == IDX_LAST)));
    end

    // State and output registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            beat_r        <= {IN_WIDTH{1'b0}};
            beat_valid_r  <= 1'b0;
            beat_last_r   <= 1'b0;
            idx_r         <= {IDX_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            tdata_r       <= {PIXEL_WIDTH{1'b0}};
            tlast_r       <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            beat_r        <= beat_nxt_s;
            beat_valid_r  <= beat_valid_nxt_s;
            beat_last_r   <= beat_last_nxt_s;
            idx_r         <= idx_nxt_s;
            cnt_r         <= cnt_nxt_s;
            tdata_r       <= pixel_at(beat_nxt_s, idx_nxt_s);
            tlast_r       <= tlast_nxt_s;
            frame_error_r <= frame_error_nxt_s;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tvalid = beat_valid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tlast  = tlast_r;
    assign frame_error   = frame_error_r;

endmodule

// File: tb/tb_display_pixel_serializer.sv
// Bench for display_pixel_serializer: two instances (full-size frame and a 6-pixel frame) share
// one stimulus stream; a pixel-queue reference model checks both every cycle.
module tb_display_pixel_serializer;

    localparam int FP_A = 153600;
    localparam int FP_B = 6;

    logic        aclk = 1'b0;
    logic        reset;
    logic        s_tvalid;
    logic        s_tlast;
    logic [63:0] s_tdata;
    logic        m_tready;

    logic        a_s_tready, a_m_tvalid, a_m_tlast, a_ferr;
    logic [15:0] a_m_tdata;
    logic        b_s_tready, b_m_tvalid, b_m_tlast, b_ferr;
    logic [15:0] b_m_tdata;

    always #5 aclk = ~aclk;

    display_pixel_serializer #(.IN_WIDTH(64), .PIXEL_WIDTH(16), .FRAME_PIXELS(FP_A)) u_a (
        .aclk(aclk), .reset(reset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(a_s_tready), .s_axis_tlast(s_tlast),
        .s_axis_tdata(s_tdata),
        .m_axis_tvalid(a_m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(a_m_tlast),
        .m_axis_tdata(a_m_tdata), .frame_error(a_ferr)
    );

    display_pixel_serializer #(.IN_WIDTH(64), .PIXEL_WIDTH(16), .FRAME_PIXELS(FP_B)) u_b (
        .aclk(aclk), .reset(reset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tlast(s_tlast),
        .s_axis_tdata(s_tdata),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(b_m_tlast),
        .m_axis_tdata(b_m_tdata), .frame_error(b_ferr)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending pixels plus per-frame position for each instance.
    typedef struct packed { logic [15:0] d; logic lst; } pix_t;
    pix_t q[$];
    int   pos_a = 0, pos_b = 0;
    logic pend_a = 1'b0, pend_b = 1'b0;
    logic mon_en = 1'b0;
    int   tl_cnt_a = 0, tl_cnt_b = 0, err_cnt_a = 0, err_cnt_b = 0;
    logic mv, mr, ml_a, ml_b;

    always @(negedge aclk) begin
        #2;
        if (mon_en) begin
            chk("ferr_a", 64'(a_ferr), 64'(pend_a));
            chk("ferr_b", 64'(b_ferr), 64'(pend_b));
            mv = (q.size() != 0);
            mr = !mv || (m_tready && q.size() == 1);
            chk("tvalid_a", 64'(a_m_tvalid), 64'(mv));
            chk("tvalid_b", 64'(b_m_tvalid), 64'(mv));
            chk("sready_a", 64'(a_s_tready), 64'(mr));
            chk("sready_b", 64'(b_s_tready), 64'(mr));
            ml_a = 1'b0;
            ml_b = 1'b0;
            if (mv) begin
                ml_a = (pos_a == FP_A - 1) || q[0].lst;
                ml_b = (pos_b == FP_B - 1) || q[0].lst;
                chk("tdata_a", 64'(a_m_tdata), 64'(q[0].d));
                chk("tdata_b", 64'(b_m_tdata), 64'(q[0].d));
            end
            chk("tlast_a", 64'(a_m_tlast), 64'(ml_a));
            chk("tlast_b", 64'(b_m_tlast), 64'(ml_b));
            err_cnt_a += int'(a_ferr);
            err_cnt_b += int'(b_ferr);
            if (reset) begin
                q.delete();
                pos_a = 0; pos_b = 0;
                pend_a = 1'b0; pend_b = 1'b0;
            end else begin
                pend_a = 1'b0;
                pend_b = 1'b0;
                if (mv && m_tready) begin
                    pend_a = q[0].lst && (pos_a != FP_A - 1);
                    pend_b = q[0].lst && (pos_b != FP_B - 1);
                    tl_cnt_a += int'(a_m_tlast);
                    tl_cnt_b += int'(b_m_tlast);
                    pos_a = ml_a ? 0 : pos_a + 1;
                    pos_b = ml_b ? 0 : pos_b + 1;
                    void'(q.pop_front());
                end
                if (s_tvalid && mr) begin
                    for (int k = 0; k < 4; k++)
                        q.push_back({s_tdata[k*16 +: 16], (k == 3) && s_tlast});
                end
            end
        end
    end

    task automatic clear_counts();
        tl_cnt_a = 0; tl_cnt_b = 0; err_cnt_a = 0; err_cnt_b = 0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        @(negedge aclk);
        reset = 1'b0;
    endtask

    // Offers nbeats beats with random valid gaps and random downstream ready; returns cycles used.
    task automatic run_stream(input int nbeats, input int tlast_beat, input int rdy_pct,
                              input int vld_pct, input int tl_pct, output int cyc);
        int  i = 0;
        logic accepted = 1'b0;
        cyc = 0;
        while (i < nbeats && cyc < nbeats * 64 + 100) begin
            @(negedge aclk);
            cyc++;
            if (accepted) s_tvalid = 1'b0;
            accepted = 1'b0;
            m_tready = (($urandom % 100) < rdy_pct);
            if (!s_tvalid && (($urandom % 100) < vld_pct)) begin
                s_tvalid = 1'b1;
                s_tdata  = {$urandom, $urandom};
                s_tlast  = (i == tlast_beat) || (($urandom % 100) < tl_pct);
            end
            #1;
            if (s_tvalid && a_s_tready) begin
                accepted = 1'b1;
                i++;
            end
        end
        tests++;
        if (i < nbeats) begin
            fails++;
            $display("FAIL stream_timeout: got %0d beats required %0d", i, nbeats);
        end
    endtask

    task automatic drain();
        int k;
        @(negedge aclk);
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        for (k = 0; k < 12; k++) begin
            #1;
            if (!a_m_tvalid && !b_m_tvalid) break;
            @(negedge aclk);
        end
        tests++;
        if (k == 12) begin
            fails++;
            $display("FAIL drain_timeout: got tvalid %0b required 0", a_m_tvalid);
        end
    endtask

    typedef struct {
        logic        sv;
        logic [63:0] sd;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic        el;
        logic        er;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [63:0] ba, bb;
        ba = 64'h0004_0003_0002_0001;
        bb = 64'h0008_0007_0006_0005;
        tbl[0]  = '{1'b1, ba,     1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 64'h0,  1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 64'h0,  1'b1, 1'b1, 16'h0002, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 64'h0,  1'b1, 1'b1, 16'h0003, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, bb,     1'b1, 1'b1, 16'h0004, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 64'h0,  1'b0, 1'b1, 16'h0005, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, ba,     1'b0, 1'b1, 16'h0005, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 64'h0,  1'b1, 1'b1, 16'h0005, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 64'h0,  1'b1, 1'b1, 16'h0006, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 64'h0,  1'b1, 1'b1, 16'h0007, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 64'h0,  1'b1, 1'b1, 16'h0008, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 64'h0,  1'b1, 1'b0, 16'h0005, 1'b0, 1'b1};

        reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 64'h0; m_tready = 1'b0;
        repeat (3) @(negedge aclk);
        reset = 1'b0;
        mon_en = 1'b1;

        // Directed first-beat, back-to-back and stall sequence.
        for (int r = 0; r < 12; r++) begin
            @(negedge aclk);
            s_tvalid = tbl[r].sv; s_tdata = tbl[r].sd; s_tlast = 1'b0; m_tready = tbl[r].rdy;
            #1;
            chk($sformatf("tbl%0d_tvalid", r), 64'(a_m_tvalid), 64'(tbl[r].ev));
            chk($sformatf("tbl%0d_tdata", r), 64'(a_m_tdata), 64'(tbl[r].ed));
            chk($sformatf("tbl%0d_tlast", r), 64'(a_m_tlast), 64'(tbl[r].el));
            chk($sformatf("tbl%0d_sready", r), 64'(a_s_tready), 64'(tbl[r].er));
        end

        // Continuous full-rate stream: no bubbles, short frame wraps every 6 pixels.
        do_reset();
        clear_counts();
        run_stream(30, -1, 100, 100, 0, cyc);
        chk("cont_cycles", 64'(cyc), 64'(4 * 29 + 1));
        drain();
        chk("cont_tlast_a", 64'(tl_cnt_a), 64'(0));
        chk("cont_tlast_b", 64'(tl_cnt_b), 64'(20));
        chk("cont_err_a", 64'(err_cnt_a), 64'(0));
        chk("cont_err_b", 64'(err_cnt_b), 64'(0));

        // Early DMA tlast on beat 2: tlast on pixel 11 and one frame_error pulse on the big frame.
        do_reset();
        clear_counts();
        run_stream(5, 2, 100, 100, 0, cyc);
        drain();
        chk("early_tlast_a", 64'(tl_cnt_a), 64'(1));
        chk("early_err_a", 64'(err_cnt_a), 64'(1));
        chk("early_tlast_b", 64'(tl_cnt_b), 64'(3));
        chk("early_err_b", 64'(err_cnt_b), 64'(0));

        // Reset while the buffered beat is at idx 2.
        do_reset();
        @(negedge aclk);
        s_tvalid = 1'b1; s_tdata = 64'h00dd_00cc_00bb_00aa; s_tlast = 1'b0; m_tready = 1'b1;
        #1 chk("mid_accept", 64'(a_s_tready), 64'(1));
        @(negedge aclk);
        s_tvalid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        #1 chk("mid_idx2_data", 64'(a_m_tdata), 64'(16'h00cc));
        reset = 1'b1;
        @(negedge aclk);
        reset = 1'b0;
        #1;
        chk("mid_rst_tvalid_a", 64'(a_m_tvalid), 64'(0));
        chk("mid_rst_tvalid_b", 64'(b_m_tvalid), 64'(0));
        clear_counts();
        run_stream(3, -1, 100, 100, 0, cyc);
        drain();
        chk("mid_tlast_b", 64'(tl_cnt_b), 64'(2));

        // Randomised traffic with random stalls and occasional DMA tlast.
        clear_counts();
        run_stream(300, -1, 50, 70, 10, cyc);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
